// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory byte loader.
//   - default geometry of the target memory (word-address width, depth)
//   - 3-bit loader state encoding
//   - small helpers for the running checksum and the byte-accepting states
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DEPTH  = 2048;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  // Running XOR over the length bytes and every data byte.
  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  // States in which the loader pulls a byte from the stream.
  function automatic logic accepts_bytes(input state_e st);
    logic acc;
    case (st)
      ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: acc = 1'b1;
      default:                            acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
// Frame: length L (2 bytes, LSB first), 4*L data bytes (little-endian words),
// one checksum byte = XOR of the length and data bytes. The processor is held
// (w_hold=1) until a frame with a matching checksum has been written.
// Ports:
//   w_clk, w_rst_n           clock, asynchronous active-low reset
//   w_start                  single-cycle load request (honoured in IDLE/DONE/ERR)
//   w_byte_valid/w_byte      byte source, transfer when valid && ready
//   w_byte_ready             loader accepts a byte this cycle
//   w_mem_we/addr/din        instruction-memory write port, one pulse per word
//   w_hold, w_done, w_err    processor hold, load success / failure levels
//   w_word_cnt               words written in the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_start,
  input  logic              w_byte_valid,
  input  logic [7:0]        w_byte,
  output logic              w_byte_ready,
  output logic              w_mem_we,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [31:0]       w_mem_din,
  output logic              w_hold,
  output logic              w_done,
  output logic              w_err,
  output logic [15:0]       w_word_cnt
);

  state_e state_r;
  state_e next_state_s;

  // Datapath registers
  logic [15:0] len_r;
  logic [1:0]  byte_idx_r;
  logic [15:0] word_idx_r;
  logic [7:0]  csum_r;
  logic [31:0] shift_r;

  // Output registers and their next values
  logic              ready_r, ready_nxt_s;
  logic              we_r, we_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [31:0]       din_r, din_nxt_s;
  logic              hold_r, hold_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic [15:0]       cnt_r, cnt_nxt_s;

  logic        xfer_s;
  logic        restart_s;
  logic [15:0] len_full_s;
  logic        len_too_big_s;
  logic        len_zero_s;
  logic        last_word_s;
  logic [31:0] shift_next_s;

  // ready_r mirrors the current state, so it is the handshake qualifier.
  assign xfer_s        = w_byte_valid && ready_r;
  assign restart_s     = w_start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
  assign len_full_s    = {w_byte, len_r[7:0]};
  assign len_too_big_s = ({16'd0, len_full_s} > 32'(DEPTH));
  assign len_zero_s    = (len_full_s == 16'd0);
  assign last_word_s   = ((word_idx_r + 16'd1) == len_r);
  // New byte enters at the top so the first byte ends up in bits 7:0.
  assign shift_next_s  = {w_byte, shift_r[31:8]};

  // State register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (restart_s) next_state_s = ST_LEN0;
        else           next_state_s = state_r;
      end
      ST_LEN0: begin
        if (xfer_s) next_state_s = ST_LEN1;
        else        next_state_s = ST_LEN0;
      end
      ST_LEN1: begin
        if (!xfer_s)            next_state_s = ST_LEN1;
        else if (len_too_big_s) next_state_s = ST_ERR;
        else if (len_zero_s)    next_state_s = ST_CSUM;
        else                    next_state_s = ST_DATA;
      end
      ST_DATA: begin
        if (xfer_s && (byte_idx_r == 2'd3)) next_state_s = ST_WRITE;
        else                                next_state_s = ST_DATA;
      end
      ST_WRITE: begin
        if (last_word_s) next_state_s = ST_CSUM;
        else             next_state_s = ST_DATA;
      end
      ST_CSUM: begin
        if (!xfer_s)               next_state_s = ST_CSUM;
        else if (w_byte == csum_r) next_state_s = ST_DONE;
        else                       next_state_s = ST_ERR;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Length, word assembly, indices and running checksum
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      len_r      <= 16'd0;
      byte_idx_r <= 2'd0;
      word_idx_r <= 16'd0;
      csum_r     <= 8'd0;
      shift_r    <= 32'd0;
    end else if (restart_s) begin
      len_r      <= 16'd0;
      byte_idx_r <= 2'd0;
      word_idx_r <= 16'd0;
      csum_r     <= 8'd0;
      shift_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_LEN0: begin
          if (xfer_s) begin
            len_r[7:0] <= w_byte;
            csum_r     <= csum_update(csum_r, w_byte);
          end
        end
        ST_LEN1: begin
          if (xfer_s) begin
            len_r[15:8] <= w_byte;
            csum_r      <= csum_update(csum_r, w_byte);
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            shift_r    <= shift_next_s;
            byte_idx_r <= byte_idx_r + 2'd1;
            csum_r     <= csum_update(csum_r, w_byte);
          end
        end
        ST_WRITE: begin
          word_idx_r <= word_idx_r + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: next values of the registered outputs, keyed on the next state
  always_comb begin
    ready_nxt_s = accepts_bytes(next_state_s);
    we_nxt_s    = (next_state_s == ST_WRITE);
    hold_nxt_s  = (next_state_s != ST_DONE);
    done_nxt_s  = (next_state_s == ST_DONE);
    err_nxt_s   = (next_state_s == ST_ERR);
    // WRITE is only entered from DATA on the 4th byte, so shift_next_s is the full word.
    if (next_state_s == ST_WRITE) begin
      addr_nxt_s = word_idx_r[ADDR_W-1:0];
      din_nxt_s  = shift_next_s;
    end else begin
      addr_nxt_s = addr_r;
      din_nxt_s  = din_r;
    end
    if (restart_s) begin
      cnt_nxt_s = 16'd0;
    end else if (state_r == ST_WRITE) begin
      cnt_nxt_s = cnt_r + 16'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Output registers
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      din_r   <= 32'd0;
      hold_r  <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      ready_r <= ready_nxt_s;
      we_r    <= we_nxt_s;
      addr_r  <= addr_nxt_s;
      din_r   <= din_nxt_s;
      hold_r  <= hold_nxt_s;
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign w_byte_ready = ready_r;
  assign w_mem_we     = we_r;
  assign w_mem_addr   = addr_r;
  assign w_mem_din    = din_r;
  assign w_hold       = hold_r;
  assign w_done       = done_r;
  assign w_err        = err_r;
  assign w_word_cnt   = cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized bench for imem_loader. Frames are
// built from word lists by a reference model; every memory write observed on
// the port is logged and compared against the word list.
module tb_imem_loader;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_start = 1'b0;
  logic        w_byte_valid = 1'b0;
  logic [7:0]  w_byte = 8'd0;
  logic        w_byte_ready;
  logic        w_mem_we;
  logic [10:0] w_mem_addr;
  logic [31:0] w_mem_din;
  logic        w_hold;
  logic        w_done;
  logic        w_err;
  logic [15:0] w_word_cnt;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] words_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] log_addr_q[$];
  logic [31:0] log_din_q[$];
  int          ready_in_write = 0;

  imem_loader dut (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .w_start      (w_start),
    .w_byte_valid (w_byte_valid),
    .w_byte       (w_byte),
    .w_byte_ready (w_byte_ready),
    .w_mem_we     (w_mem_we),
    .w_mem_addr   (w_mem_addr),
    .w_mem_din    (w_mem_din),
    .w_hold       (w_hold),
    .w_done       (w_done),
    .w_err        (w_err),
    .w_word_cnt   (w_word_cnt)
  );

  always #5 w_clk = ~w_clk;

  // Write-port monitor
  always @(negedge w_clk) begin
    if (w_mem_we) begin
      log_addr_q.push_back({21'd0, w_mem_addr});
      log_din_q.push_back(w_mem_din);
      if (w_byte_ready) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference frame: length bytes, little-endian words, XOR checksum (optionally corrupted).
  task automatic build_frame(input logic [15:0] len, input logic [7:0] csum_flip);
    logic [7:0] c;
    c = 8'd0;
    frame_q.delete();
    frame_q.push_back(len[7:0]);
    frame_q.push_back(len[15:8]);
    foreach (words_q[i])
      for (int b = 0; b < 4; b++) frame_q.push_back(words_q[i][8*b +: 8]);
    foreach (frame_q[i]) c = c ^ frame_q[i];
    frame_q.push_back(c ^ csum_flip);
  endtask

  task automatic random_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  task automatic clear_log();
    log_addr_q.delete();
    log_din_q.delete();
    ready_in_write = 0;
  endtask

  task automatic pulse_start();
    w_start = 1'b1;
    @(posedge w_clk); #1;
    w_start = 1'b0;
  endtask

  // mode 0: valid always, 1: valid every other cycle, else random valid
  task automatic send_bytes(input int first, input int count, input int mode);
    int idx;
    int cyc;
    bit xfer;
    idx = first;
    cyc = 0;
    while (idx < first + count && cyc < 40 * count + 40) begin
      w_byte = frame_q[idx];
      case (mode)
        0:       w_byte_valid = 1'b1;
        1:       w_byte_valid = cyc[0];
        default: w_byte_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge w_clk);
      xfer = w_byte_valid && w_byte_ready;
      @(posedge w_clk); #1;
      if (xfer) idx++;
      cyc++;
    end
    w_byte_valid = 1'b0;
    check("send_complete", idx, first + count);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, log_addr_q.size(), words_q.size());
    for (int i = 0; i < log_addr_q.size() && i < words_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_addr_q[i], i);
      check($sformatf("%s_din%0d", tag, i), log_din_q[i], words_q[i]);
    end
    check({tag, "_ready_in_write"}, ready_in_write, 0);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic hold, input logic [15:0] cnt);
    check({tag, "_done"}, w_done, done);
    check({tag, "_err"}, w_err, err);
    check({tag, "_hold"}, w_hold, hold);
    check({tag, "_word_cnt"}, w_word_cnt, cnt);
  endtask

  initial begin
    // Reset values
    #12;
    check_status("rst", 1'b0, 1'b0, 1'b1, 16'd0);
    check("rst_ready", w_byte_ready, 1'b0);
    check("rst_we", w_mem_we, 1'b0);
    check("rst_addr", w_mem_addr, 11'd0);
    check("rst_din", w_mem_din, 32'd0);
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
    @(posedge w_clk); #1;
    check_status("idle", 1'b0, 1'b0, 1'b1, 16'd0);

    // Single word, valid always: 01 00 04 00 01 8C 88
    clear_log();
    words_q.delete();
    words_q.push_back(32'h8C01_0004);
    build_frame(16'd1, 8'h00);
    pulse_start();
    send_bytes(0, frame_q.size(), 0);
    @(posedge w_clk); #1;
    check_writes("one");
    check_status("one", 1'b1, 1'b0, 1'b0, 16'd1);

    // Two random words, valid toggling
    clear_log();
    random_words(2);
    build_frame(16'd2, 8'h00);
    pulse_start();
    check_status("two_started", 1'b0, 1'b0, 1'b1, 16'd0);
    send_bytes(0, frame_q.size(), 1);
    @(posedge w_clk); #1;
    check_writes("two");
    check_status("two", 1'b1, 1'b0, 1'b0, 16'd2);

    // Bad checksum
    clear_log();
    words_q.delete();
    words_q.push_back(32'h8C01_0004);
    build_frame(16'd1, 8'h01);
    pulse_start();
    send_bytes(0, frame_q.size(), 0);
    check_status("badcs", 1'b0, 1'b1, 1'b1, 16'd1);
    @(posedge w_clk); #1;
    check_writes("badcs");

    // Oversized length 2049
    clear_log();
    words_q.delete();
    build_frame(16'd2049, 8'h00);
    pulse_start();
    send_bytes(0, 2, 0);
    check_status("big", 1'b0, 1'b1, 1'b1, 16'd0);
    w_byte_valid = 1'b1;
    repeat (3) @(posedge w_clk);
    #1;
    check("big_ready", w_byte_ready, 1'b0);
    w_byte_valid = 1'b0;
    check_writes("big");

    // Zero length
    clear_log();
    words_q.delete();
    build_frame(16'd0, 8'h00);
    pulse_start();
    send_bytes(0, frame_q.size(), 2);
    @(posedge w_clk); #1;
    check_writes("zero");
    check_status("zero", 1'b1, 1'b0, 1'b0, 16'd0);

    // Start pulse in DATA (mid second word) must be ignored
    clear_log();
    random_words(3);
    build_frame(16'd3, 8'h00);
    pulse_start();
    send_bytes(0, 8, 2);
    pulse_start();
    check("ign_ready", w_byte_ready, 1'b1);
    check_status("ign_mid", 1'b0, 1'b0, 1'b1, 16'd1);
    send_bytes(8, frame_q.size() - 8, 2);
    @(posedge w_clk); #1;
    check_writes("ign");
    check_status("ign", 1'b1, 1'b0, 1'b0, 16'd3);

    // Asynchronous reset in the middle of the second word
    clear_log();
    random_words(3);
    build_frame(16'd3, 8'h00);
    pulse_start();
    send_bytes(0, 8, 0);
    #2;
    w_rst_n = 1'b0;
    #1;
    check_status("arst", 1'b0, 1'b0, 1'b1, 16'd0);
    check("arst_ready", w_byte_ready, 1'b0);
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
    @(posedge w_clk); #1;

    // Clean reload after reset
    clear_log();
    words_q.delete();
    words_q.push_back(32'h8C01_0004);
    build_frame(16'd1, 8'h00);
    pulse_start();
    send_bytes(0, frame_q.size(), 0);
    @(posedge w_clk); #1;
    check_writes("reload");
    check_status("reload", 1'b1, 1'b0, 1'b0, 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; writer counterpart to the processor's instruction-memory read port.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the instruction memory write port (we/addr/din) and holds the processor until a verified image is in place.
- Sits between an external byte source (UART receiver, debug VIO) and the m_amemory write port; its hold output gates the processor clock-enable/reset.

Parameters:
- ADDR_W, 11, word-address width of the target memory.
- DEPTH, 2048, maximum loadable word count; the error check compares against this.

Ports:
- w_clk  in  1  system clock, rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_start  in  1  single-cycle load request.
- w_byte_valid  in  1  source has a byte on w_byte.
- w_byte  in  8  stream byte.
- w_byte_ready  out  1  loader accepts a byte this cycle.
- w_mem_we  out  1  memory write enable, one-cycle pulse per word.
- w_mem_addr  out  ADDR_W  word address being written.
- w_mem_din  out  32  assembled word.
- w_hold  out  1  keep the processor halted; low only after a successful load.
- w_done  out  1  image loaded and checksum matched (level).
- w_err  out  1  length or checksum failure (level).
- w_word_cnt  out  16  words written in the current load.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- All outputs are registered.
- Reset values: state IDLE, hold=1, all other outputs 0. Internal byte index, word index, length, checksum and shift register are all 0.
- Byte transfer occurs on a rising edge when w_byte_valid && w_byte_ready.
- w_byte_ready=1 only in LEN0, LEN1, DATA and CSUM; it is 0 in all other states.
- Frame layout:
  - length L as 2 bytes, low byte first;
  - 4*L data bytes, each word little-endian (byte0 = bits 7:0);
  - 1 checksum byte.
- Checksum is the XOR of the 2 length bytes and all 4*L data bytes.
- States:
  - IDLE: hold=1. On w_start → LEN0, clearing counters, checksum, done and err.
  - LEN0: on transfer, latch L[7:0] → LEN1.
  - LEN1: on transfer, latch L[15:8] and evaluate the full L:
    - L > DEPTH → ERR;
    - L == 0 → CSUM;
    - else → DATA.
  - DATA: on each transfer, shift the byte into the word register and increment the byte index. On the 4th byte → WRITE.
  - WRITE (exactly 1 cycle):
    - w_mem_we=1, w_mem_addr=word index[ADDR_W-1:0], w_mem_din=assembled word;
    - then word index++ and w_word_cnt++;
    - if word index+1 == L → CSUM, else → DATA.
  - CSUM: on transfer, compare the byte with the running XOR.
    - Equal → DONE (done=1, hold=0).
    - Not equal → ERR (err=1, hold=1).
  - DONE / ERR: sticky. w_start → LEN0: hold=1, done=0, err=0, counters cleared. Memory contents are not cleared.
- w_start in LEN0, LEN1, DATA, WRITE or CSUM is ignored.
- w_mem_we is never asserted outside WRITE.
- The address never wraps, because L ≤ DEPTH is guaranteed by the LEN1 check.
- Throughput: a 5-byte-time minimum per word, since ready drops for the WRITE cycle.
- Reset asserted mid-load: immediate return to IDLE with hold=1. Partially written memory is left as is.
- w_byte_valid held with ready=0 causes no state change.

Decomposition:
- Shared package holds the state encoding constants: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR as a 3-bit code.
- Single module. No sub-module is warranted.
- The byte-to-word shifter stays inline.

Test Plan:
- Reset, then w_start; stream 01 00 04 00 01 8C 88 with valid always 1. Required: exactly one we pulse, addr=0, din=0x8C010004; then done=1, hold=0, err=0, w_word_cnt=1.
- Two-word load (L=2) with valid toggling every other cycle. Required:
  - we at addr 0 then addr 1 with the correct words;
  - ready=0 in each WRITE cycle;
  - no byte lost or duplicated.
- Same frame as the first test but checksum byte 0x89. Required: word written; then err=1, done=0, hold=1.
- Length bytes 01 08 (L=2049 > DEPTH). Required: ERR immediately after the second length byte, no we pulse, ready=0 afterwards.
- L=0 (00 00 00). Required: DONE, no we, w_word_cnt=0.
- Reset in the middle of the second word, then w_start and the full first-test frame. Required: hold=1 immediately at reset; the clean reload reaches DONE. A w_start issued in DATA is ignored.
